// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: settles and decodes a multiplexed active-low 7-seg bus per digit (optional SEG7_SCAN_READER_DP_EN adds decimal point)
module seg7_scan_reader #(
  parameter int DIGITS = 4,
  parameter int STABLE_CYC = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   dout,
  output logic [DIGITS-1:0]     dout_valid,
  output logic [DIGITS-1:0]     bad_pat,
  output logic                  upd,
  output logic [2:0]            upd_idx
`ifdef SEG7_SCAN_READER_DP_EN
  ,
  input  logic                  dp_n,
  output logic [DIGITS-1:0]     dp_out
`endif
);
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int AW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
`ifdef SEG7_SCAN_READER_DP_EN
  localparam int BW = DIGITS + 8;
  logic [BW-1:0] bus;
  assign bus = {dp_n, an_n, seg_n};
`else
  localparam int BW = DIGITS + 7;
  logic [BW-1:0] bus;
  assign bus = {an_n, seg_n};
`endif
  logic [BW-1:0] in_r, in_p;
  logic [DIGITS-1:0] an_r, expire;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] age [DIGITS];
  logic sel, same, cap;
  logic [2:0] idx;
  logic [4:0] dec;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = 5'h10;
      7'h79: decode = 5'h11;
      7'h24: decode = 5'h12;
      7'h30: decode = 5'h13;
      7'h19: decode = 5'h14;
      7'h12: decode = 5'h15;
      7'h02: decode = 5'h16;
      7'h78: decode = 5'h17;
      7'h00: decode = 5'h18;
      7'h10: decode = 5'h19;
      7'h08: decode = 5'h1A;
      7'h03: decode = 5'h1B;
      7'h46: decode = 5'h1C;
      7'h21: decode = 5'h1D;
      7'h06: decode = 5'h1E;
      7'h0E: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  assign an_r = in_r[7 +: DIGITS];

  always_comb begin
    sel = $onehot(~an_r);
    same = in_r == in_p;
    cnt_nxt = !sel ? '0 : !same ? CW'(1) : (cnt == CW'(STABLE_CYC) ? cnt : cnt + 1'b1);
    // a change that lands straight on the threshold (STABLE_CYC=1) is still a new visit
    cap = sel && cnt_nxt == CW'(STABLE_CYC) && (!same || cnt != CW'(STABLE_CYC));
    dec = decode(in_r[6:0]);
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (!an_r[i]) idx = 3'(i);
    for (int i = 0; i < DIGITS; i++)
      expire[i] = TIMEOUT > 0 && age[i] >= AW'(TIMEOUT - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_r <= '1;
      in_p <= '1;
      cnt <= '0;
      dout <= '0;
      dout_valid <= '0;
      bad_pat <= '0;
      upd <= 1'b0;
      upd_idx <= '0;
`ifdef SEG7_SCAN_READER_DP_EN
      dp_out <= '0;
`endif
      for (int i = 0; i < DIGITS; i++) age[i] <= '0;
    end else begin
      in_r <= bus;
      in_p <= in_r;
      cnt <= cnt_nxt;
      upd <= cap;
      upd_idx <= cap ? idx : upd_idx;
      for (int i = 0; i < DIGITS; i++) begin
        if (cap && idx == 3'(i)) begin
          if (dec[4]) dout[4*i +: 4] <= dec[3:0];
          dout_valid[i] <= dec[4];
          bad_pat[i] <= !dec[4];
`ifdef SEG7_SCAN_READER_DP_EN
          dp_out[i] <= ~in_r[BW-1];
`endif
        end else if (expire[i]) begin
          dout_valid[i] <= 1'b0;
        end
        age[i] <= (cap && idx == 3'(i)) ? '0 :
                  (TIMEOUT == 0 || age[i] == AW'(TIMEOUT)) ? age[i] : age[i] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: randomized and directed checks against a run-length/edge-count reference model
module tb_seg7_scan_reader;
  localparam int D = 4, S = 4, T = 20;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] seg_n = '1;
  logic [3:0] an_n = '1;
  logic [15:0] dout;
  logic [3:0] dout_valid, bad_pat;
  logic upd;
  logic [2:0] upd_idx;
  logic [27:0] obs;
`ifdef SEG7_SCAN_READER_DP_EN
  logic dp_n = 1'b1;
  logic [3:0] dp_out;
`endif

  always #5 clk = ~clk;

  seg7_scan_reader #(.DIGITS(D), .STABLE_CYC(S), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n), .dout(dout),
    .dout_valid(dout_valid), .bad_pat(bad_pat), .upd(upd), .upd_idx(upd_idx)
`ifdef SEG7_SCAN_READER_DP_EN
    , .dp_n(dp_n), .dp_out(dp_out)
`endif
  );

  assign obs = {dout, dout_valid, bad_pat, upd, upd_idx};

  int checks = 0, failures = 0;
  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [3:0] m_dout [4];
  bit m_legal [4], m_bad [4];
  int cap_edge [4];
  bit m_upd, pend;
  int m_idx, run, edge_n, pend_idx, upd_cnt;
  logic [10:0] last;
  logic [6:0] pend_seg;

  function automatic logic [27:0] exp_vec();
    logic [15:0] d;
    logic [3:0] v, b;
    for (int i = 0; i < 4; i++) begin
      d[4*i +: 4] = m_dout[i];
      v[i] = m_legal[i] && (edge_n - cap_edge[i] < T);
      b[i] = m_bad[i];
    end
    return {d, v, b, m_upd, 3'(m_idx)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_dout[i] = 0; m_legal[i] = 0; m_bad[i] = 0; cap_edge[i] = -1000;
    end
    m_upd = 0; m_idx = 0; run = 0; edge_n = 0; pend = 0; last = '1;
  endtask

  task automatic do_reset();
    rst = 1'b1; an_n = '1; seg_n = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] s);
    int n;
    an_n = a; seg_n = s;
    @(posedge clk);
    edge_n++;
    m_upd = 0;
    if (pend) begin
      m_upd = 1; m_idx = pend_idx; cap_edge[pend_idx] = edge_n;
      n = -1;
      for (int k = 0; k < 16; k++) if (pat[k] == pend_seg) n = k;
      if (n >= 0) begin
        m_dout[pend_idx] = 4'(n); m_legal[pend_idx] = 1; m_bad[pend_idx] = 0;
      end else begin
        m_legal[pend_idx] = 0; m_bad[pend_idx] = 1;
      end
    end
    if ($countones(~a) != 1) run = 0;
    else if ({a, s} == last) run++;
    else run = 1;
    last = {a, s};
    pend = run == S;
    for (int i = 0; i < 4; i++) if (!a[i]) pend_idx = i;
    pend_seg = s;
    #1;
    if (upd) upd_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== 28'h0) begin
      failures++; $display("FAIL reset: got %h want %h", obs, 28'h0);
    end
  endtask

  task automatic test_single_hold();
    do_reset();
    upd_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step(4'b1110, 7'h30);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL hold edge %0d: got %h want %h", k, obs, exp_vec());
      end
      if (k == 5) begin
        checks++;
        if ({upd, dout[3:0], dout_valid} !== {1'b1, 4'h3, 4'b0001}) begin
          failures++; $display("FAIL hold_e5: got %b want %b", {upd, dout[3:0], dout_valid}, {1'b1, 4'h3, 4'b0001});
        end
      end
    end
    checks++;
    if (upd_cnt !== 1) begin
      failures++; $display("FAIL hold_count: got %0d want 1", upd_cnt);
    end
  endtask

  task automatic test_scan();
    logic [6:0] sp [4] = '{7'h12, 7'h03, 7'h46, 7'h0E};
    do_reset();
    upd_cnt = 0;
    for (int r = 0; r < 3; r++)
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 4; c++) begin
          step(~(4'b1 << d), sp[d]);
          checks++;
          if (obs !== exp_vec()) begin
            failures++; $display("FAIL scan r%0d d%0d c%0d: got %h want %h", r, d, c, obs, exp_vec());
          end
        end
    step(4'b1111, 7'h7F);
    checks++;
    if ({dout, dout_valid} !== {16'hFCB5, 4'hF} || upd_cnt !== 12) begin
      failures++; $display("FAIL scan_final: got %h/%h/%0d want FCB5/F/12", dout, dout_valid, upd_cnt);
    end
  endtask

  task automatic test_toggle_and_multi();
    upd_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(4'b1110, (k / 2) % 2 ? 7'h24 : 7'h30);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL toggle %0d: got %h want %h", k, obs, exp_vec());
      end
    end
    for (int k = 0; k < 40; k++) begin
      step(k < 20 ? 4'b1100 : 4'b1111, 7'h00);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL multi %0d: got %h want %h", k, obs, exp_vec());
      end
    end
    checks++;
    if (upd_cnt !== 0) begin
      failures++; $display("FAIL no_upd: got %0d want 0", upd_cnt);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(4'b1011, k < 5 ? 7'h19 : 7'h7F);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL illegal %0d: got %h want %h", k, obs, exp_vec());
      end
    end
    step(4'b1111, 7'h7F);
    checks++;
    if ({dout[11:8], dout_valid[2], bad_pat[2]} !== {4'h4, 1'b0, 1'b1}) begin
      failures++; $display("FAIL illegal_final: got %b want %b", {dout[11:8], dout_valid[2], bad_pat[2]}, {4'h4, 1'b0, 1'b1});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      step(k <= 4 ? 4'b1101 : 4'b1111, 7'h79);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL timeout edge %0d: got %h want %h", k, obs, exp_vec());
      end
      if (k == 24 || k == 25) begin
        checks++;
        if (dout_valid[1] !== (k == 24)) begin
          failures++; $display("FAIL expiry edge %0d: got %b want %b", k, dout_valid[1], k == 24);
        end
      end
    end
    do_reset();
    for (int k = 1; k <= 28; k++) begin
      step((k <= 4 || (k >= 21 && k <= 24)) ? 4'b1101 : 4'b1111, k <= 4 ? 7'h79 : 7'h24);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL collide edge %0d: got %h want %h", k, obs, exp_vec());
      end
      if (k == 25) begin
        checks++;
        if ({upd, dout_valid[1], dout[7:4]} !== {1'b1, 1'b1, 4'h2}) begin
          failures++; $display("FAIL collide_win: got %b want %b", {upd, dout_valid[1], dout[7:4]}, {1'b1, 1'b1, 4'h2});
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic [6:0] s;
    int hold;
    do_reset();
    for (int n = 0; n < 120; n++) begin
      a = $urandom_range(0, 4) == 4 ? 4'($urandom) : ~(4'b1 << $urandom_range(0, 3));
      s = $urandom_range(0, 3) == 0 ? 7'($urandom) : pat[$urandom_range(0, 15)];
      hold = $urandom_range(1, 7);
      for (int c = 0; c < hold; c++) begin
        step(a, s);
        checks++;
        if (obs !== exp_vec()) begin
          failures++; $display("FAIL random n%0d c%0d: got %h want %h", n, c, obs, exp_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_hold();
    test_scan();
    test_toggle_and_multi();
    test_illegal();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
